// File: rtl/sample_packer.sv
// Packs a stream of quantized sample bytes into 16-bit words grouped into packets.
// The packet length is clamped and latched at each packet start.
module sample_packer #(
    parameter int unsigned MIN_WORDS = 16,
    parameter int unsigned MAX_WORDS = 746
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [7:0]  sample,
    input  logic        enable,
    input  logic [9:0]  packet_words,
    output logic [15:0] source_data,
    output logic        source_en,
    output logic        source_packet_end,
    output logic [15:0] packet_count,
    output logic        active
);

    // Length limits are kept within 1..1023 so the 10-bit word counter can hold them.
    localparam int unsigned MIN_CAP = (MIN_WORDS < 1) ? 1 : ((MIN_WORDS > 1023) ? 1023 : MIN_WORDS);
    localparam int unsigned MAX_CAP = (MAX_WORDS > 1023) ? 1023 : ((MAX_WORDS < MIN_CAP) ? MIN_CAP : MAX_WORDS);
    localparam logic [9:0] MIN_L = 10'(MIN_CAP);
    localparam logic [9:0] MAX_L = 10'(MAX_CAP);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [9:0]  r_len;
    logic [9:0]  r_word_cnt;
    logic        r_half;
    logic [7:0]  r_high;

    logic [9:0]  w_len;
    logic        w_last;

    assign w_len  = (packet_words < MIN_L) ? MIN_L :
                    (packet_words > MAX_L) ? MAX_L : packet_words;
    assign w_last = (r_word_cnt == (r_len - 10'd1));
    assign active = (r_state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= IDLE;
            r_len             <= MIN_L;
            r_word_cnt        <= 10'd0;
            r_half            <= 1'b0;
            r_high            <= 8'd0;
            source_data       <= 16'd0;
            source_en         <= 1'b0;
            source_packet_end <= 1'b0;
            packet_count      <= 16'd0;
        end else begin
            source_en         <= 1'b0;
            source_packet_end <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state    <= RUN;
                        r_len      <= w_len;
                        r_word_cnt <= 10'd0;
                        r_half     <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_valid) begin
                        if (!r_half) begin
                            r_high <= sample;
                            r_half <= 1'b1;
                        end else begin
                            r_half      <= 1'b0;
                            source_data <= {r_high, sample};
                            source_en   <= 1'b1;
                            if (w_last) begin
                                // Packet boundary: either chain straight into the next packet or stop.
                                source_packet_end <= 1'b1;
                                packet_count      <= packet_count + 16'd1;
                                r_word_cnt        <= 10'd0;
                                if (enable) begin
                                    r_len <= w_len;
                                end else begin
                                    r_state <= IDLE;
                                end
                            end else begin
                                r_word_cnt <= r_word_cnt + 10'd1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: drives byte streams, collects emitted words
// and compares them against words rebuilt from the known byte sequence.
module tb_sample_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [7:0]  sample;
    logic        enable;
    logic [9:0]  packet_words;
    logic [15:0] source_data;
    logic        source_en;
    logic        source_packet_end;
    logic [15:0] packet_count;
    logic        active;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          pair_cyc = 0;
    logic [7:0]  next_byte = 8'd0;
    logic [7:0]  base;

    logic [15:0] mon_data[$];
    logic        mon_end[$];
    int          mon_cyc[$];

    sample_packer #(.MIN_WORDS(16), .MAX_WORDS(746)) dut (
        .clk               (clk),
        .reset             (reset),
        .sample_valid      (sample_valid),
        .sample            (sample),
        .enable            (enable),
        .packet_words      (packet_words),
        .source_data       (source_data),
        .source_en         (source_en),
        .source_packet_end (source_packet_end),
        .packet_count      (packet_count),
        .active            (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (source_en === 1'b1) begin
            mon_data.push_back(source_data);
            mon_end.push_back(source_packet_end);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_end.delete();
        mon_cyc.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic start_run(input logic [9:0] pw);
        @(negedge clk);
        enable       = 1'b1;
        packet_words = pw;
        sample_valid = 1'b0;
    endtask

    // Drives n bytes; enable drops from byte drop_at on, packet_words changes from byte pw_at on.
    task automatic feed(input int n, input int drop_at, input bit gaps,
                        input int pw_at, input logic [9:0] pw_new);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    sample_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (i >= drop_at) enable = 1'b0;
            if (i >= pw_at) packet_words = pw_new;
            sample_valid = 1'b1;
            sample       = next_byte;
            next_byte    = next_byte + 8'd1;
            if (i == 1) pair_cyc = cyc;
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic check_words(input logic [7:0] b, input int len0, input int len1);
        int tot;
        int n;
        logic [7:0] hi;
        logic [7:0] lo;
        tot = len0 + len1;
        chk("word_count", 32'(mon_data.size()), 32'(tot));
        n = (mon_data.size() < tot) ? mon_data.size() : tot;
        for (int k = 0; k < n; k++) begin
            hi = 8'(int'(b) + 2 * k);
            lo = hi + 8'd1;
            chk($sformatf("word_data[%0d]", k), 32'(mon_data[k]), {16'd0, hi, lo});
            chk($sformatf("word_end[%0d]", k), 32'(mon_end[k]),
                32'((k == len0 - 1) || (k == tot - 1)));
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample       = 8'd0;
        packet_words = 10'd16;
        repeat (3) @(negedge clk);
        chk("reset_source_en", 32'(source_en), 32'd0);
        chk("reset_packet_end", 32'(source_packet_end), 32'd0);
        chk("reset_source_data", 32'(source_data), 32'd0);
        chk("reset_packet_count", 32'(packet_count), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        reset = 1'b0;
        idle_cycles(2);
        chk("idle_active", 32'(active), 32'd0);

        // 16-word packet from bytes 0,1,2,... with continuous valid
        clear_mon();
        base = next_byte;
        start_run(10'd16);
        @(negedge clk);
        chk("run_active", 32'(active), 32'd1);
        feed(32, 31, 1'b0, 9999, 10'd16);
        idle_cycles(3);
        check_words(base, 16, 0);
        chk("first_word_latency", 32'(mon_cyc.size() > 0 ? mon_cyc[0] : -1), 32'(pair_cyc + 1));
        if (mon_cyc.size() >= 16) begin
            chk("every_other_cycle", 32'(mon_cyc[1] - mon_cyc[0]), 32'd2);
            chk("packet_span", 32'(mon_cyc[15] - mon_cyc[0]), 32'd30);
        end
        chk("pc_after_p1", 32'(packet_count), 32'd1);
        chk("active_falls", 32'(active), 32'd0);

        // Short request clamps up to the minimum
        clear_mon();
        base = next_byte;
        start_run(10'd3);
        feed(32, 31, 1'b0, 9999, 10'd3);
        idle_cycles(4);
        check_words(base, 16, 0);
        chk("pc_after_min", 32'(packet_count), 32'd2);

        // Long request clamps down to the maximum
        clear_mon();
        base = next_byte;
        start_run(10'd1000);
        feed(1492, 1491, 1'b0, 9999, 10'd1000);
        idle_cycles(4);
        check_words(base, 746, 0);
        chk("pc_after_max", 32'(packet_count), 32'd3);

        // Length change mid-packet applies only to the following packet
        clear_mon();
        base = next_byte;
        start_run(10'd16);
        feed(96, 95, 1'b0, 10, 10'd32);
        idle_cycles(4);
        check_words(base, 16, 32);
        chk("pc_after_change", 32'(packet_count), 32'd5);

        // Enable dropped at word 4 does not truncate the packet
        clear_mon();
        base = next_byte;
        packet_words = 10'd16;
        start_run(10'd16);
        feed(32, 8, 1'b0, 9999, 10'd16);
        idle_cycles(6);
        check_words(base, 16, 0);
        chk("pc_after_drop", 32'(packet_count), 32'd6);
        chk("active_after_drop", 32'(active), 32'd0);

        // Random valid gaps over two chained packets
        clear_mon();
        base = next_byte;
        start_run(10'd16);
        feed(64, 63, 1'b1, 9999, 10'd16);
        idle_cycles(4);
        check_words(base, 16, 16);
        chk("pc_after_gaps", 32'(packet_count), 32'd8);

        // Reset in the middle of word 7 with an odd byte count
        start_run(10'd16);
        feed(15, 9999, 1'b0, 9999, 10'd16);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("midreset_source_en", 32'(source_en), 32'd0);
        chk("midreset_source_data", 32'(source_data), 32'd0);
        chk("midreset_packet_count", 32'(packet_count), 32'd0);
        chk("midreset_active", 32'(active), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        next_byte = 8'hA0;
        clear_mon();
        base = next_byte;
        start_run(10'd16);
        feed(32, 31, 1'b0, 9999, 10'd16);
        idle_cycles(3);
        check_words(base, 16, 0);
        chk("pc_after_reset", 32'(packet_count), 32'd1);

        // Counter wrap from 16'hFFFF
        force dut.packet_count = 16'hFFFF;
        @(negedge clk);
        release dut.packet_count;
        @(negedge clk);
        chk("pc_preload", 32'(packet_count), 32'h0000FFFF);
        clear_mon();
        base = next_byte;
        start_run(10'd16);
        feed(32, 31, 1'b0, 9999, 10'd16);
        idle_cycles(3);
        check_words(base, 16, 0);
        chk("pc_wrap", 32'(packet_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
